// File: rtl/pipe_hazard_pkg.sv
// Shared defaults, scoreboard record and latency constants for the pipeline hazard unit.
package pipe_hazard_pkg;

    localparam int NUM_REGS_DEF       = 32;
    localparam int RAW_DEF            = 5;
    localparam int DEPTH_DEF          = 3;
    localparam int LATW_DEF           = 2;
    localparam int ZERO_HARDWIRED_DEF = 1;

    localparam int FWD_REGFILE = 0;
    localparam int LAT_ALU     = 1;
    localparam int LAT_LOAD    = 2;

    typedef struct packed {
        logic                valid;
        logic [RAW_DEF-1:0]  rd;
        logic [LATW_DEF-1:0] lat;
    } sb_entry_t;

    // Latency 0 behaves like 1; anything past the last tracked stage behaves like that stage.
    function automatic int clamp_lat(input int lat, input int depth);
        if (lat < 1) begin
            return 1;
        end else if (lat > depth) begin
            return depth;
        end
        return lat;
    endfunction

endpackage

// File: rtl/pipe_hazard_match.sv
// Per-operand priority match: youngest matching in-flight writer decides forward vs. hazard.
module pipe_hazard_match
    import pipe_hazard_pkg::*;
#(
    parameter int RAW            = RAW_DEF,
    parameter int DEPTH          = DEPTH_DEF,
    parameter bit ZERO_HARDWIRED = 1'b1,
    localparam int FW            = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0]          valid_i,
    input  logic [DEPTH-1:0][RAW-1:0] rd_i,
    input  logic [DEPTH-1:0][FW-1:0]  lat_i,
    input  logic [RAW-1:0]            op_i,
    input  logic                      used_i,
    output logic [FW-1:0]             fwd_o,
    output logic                      hazard_o
);

    logic          hit;
    logic [FW-1:0] win_k;
    logic [FW-1:0] win_lat;

    always_comb begin
        hit     = 1'b0;
        win_k   = '0;
        win_lat = '0;
        // Walk from oldest to youngest so the smallest stage index is the final winner.
        for (int k = DEPTH; k >= 1; k--) begin
            if (used_i && valid_i[k-1] && (rd_i[k-1] == op_i) &&
                !(ZERO_HARDWIRED && (op_i == '0))) begin
                hit     = 1'b1;
                win_k   = FW'(k);
                win_lat = lat_i[k-1];
            end
        end

        fwd_o    = FW'(FWD_REGFILE);
        hazard_o = 1'b0;
        if (hit) begin
            if (win_k >= win_lat) begin
                fwd_o = win_k;
            end else begin
                hazard_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// In-order pipeline hazard unit: scoreboard of in-flight writers, forwarding select and stall.
module pipe_hazard_unit
    import pipe_hazard_pkg::*;
#(
    parameter int NUM_REGS       = NUM_REGS_DEF,
    parameter int RAW            = $clog2(NUM_REGS),
    parameter int DEPTH          = DEPTH_DEF,
    parameter int LATW           = LATW_DEF,
    parameter bit ZERO_HARDWIRED = 1'(ZERO_HARDWIRED_DEF)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         id_valid,
    input  logic [RAW-1:0]               id_rs,
    input  logic [RAW-1:0]               id_rt,
    input  logic                         id_rs_used,
    input  logic                         id_rt_used,
    input  logic [RAW-1:0]               id_rd,
    input  logic                         id_wr,
    input  logic [LATW-1:0]              id_lat,
    input  logic                         flush,
    input  logic                         mem_busy,
    output logic                         stall,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_rs,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_rt,
    output logic [31:0]                  stall_cnt
);

    localparam int FW = $clog2(DEPTH + 1);

    // Index 0 holds stage 1 (EX); index DEPTH-1 holds the last tracked stage.
    logic [DEPTH-1:0]          valid_q, valid_d;
    logic [DEPTH-1:0][RAW-1:0] rd_q, rd_d;
    logic [DEPTH-1:0][FW-1:0]  lat_q, lat_d;
    logic [31:0]               stall_cnt_q, stall_cnt_d;

    logic          haz_rs;
    logic          haz_rt;
    logic          hazard;
    logic          insert;
    logic [FW-1:0] lat_in;

    pipe_hazard_match #(
        .RAW            (RAW),
        .DEPTH          (DEPTH),
        .ZERO_HARDWIRED (ZERO_HARDWIRED)
    ) u_match_rs (
        .valid_i  (valid_q),
        .rd_i     (rd_q),
        .lat_i    (lat_q),
        .op_i     (id_rs),
        .used_i   (id_rs_used),
        .fwd_o    (fwd_rs),
        .hazard_o (haz_rs)
    );

    pipe_hazard_match #(
        .RAW            (RAW),
        .DEPTH          (DEPTH),
        .ZERO_HARDWIRED (ZERO_HARDWIRED)
    ) u_match_rt (
        .valid_i  (valid_q),
        .rd_i     (rd_q),
        .lat_i    (lat_q),
        .op_i     (id_rt),
        .used_i   (id_rt_used),
        .fwd_o    (fwd_rt),
        .hazard_o (haz_rt)
    );

    // A flushed instruction never stalls and never enters the scoreboard.
    assign hazard = haz_rs | haz_rt;
    assign stall  = mem_busy | (id_valid & ~flush & hazard);
    assign insert = id_valid & id_wr & ~stall & ~flush;
    assign lat_in = FW'(clamp_lat(int'(id_lat), DEPTH));

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        lat_d   = lat_q;
        if (!mem_busy) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                valid_d[k] = valid_q[k-1];
                rd_d[k]    = rd_q[k-1];
                lat_d[k]   = lat_q[k-1];
            end
            valid_d[0] = insert;
            rd_d[0]    = id_rd;
            lat_d[0]   = lat_in;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && id_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= '0;
            rd_q        <= '0;
            lat_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            rd_q        <= rd_d;
            lat_q       <= lat_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed, table-driven bench for pipe_hazard_unit (DEPTH=3) with hand-written reset sequences.
module tb_pipe_hazard_unit;
    import pipe_hazard_pkg::*;

    localparam logic [1:0] L1 = 2'(LAT_ALU);
    localparam logic [1:0] L2 = 2'(LAT_LOAD);

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_rs_used;
    logic        id_rt_used;
    logic [4:0]  id_rd;
    logic        id_wr;
    logic [1:0]  id_lat;
    logic        flush;
    logic        mem_busy;
    logic        stall;
    logic [1:0]  fwd_rs;
    logic [1:0]  fwd_rt;
    logic [31:0] stall_cnt;

    pipe_hazard_unit dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .id_rd      (id_rd),
        .id_wr      (id_wr),
        .id_lat     (id_lat),
        .flush      (flush),
        .mem_busy   (mem_busy),
        .stall      (stall),
        .fwd_rs     (fwd_rs),
        .fwd_rt     (fwd_rt),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [4:0]  rs;
        logic        rsu;
        logic [4:0]  rt;
        logic        rtu;
        logic [4:0]  rd;
        logic        wr;
        logic [1:0]  lat;
        logic        fl;
        logic        mb;
        logic        e_stall;
        logic [1:0]  e_frs;
        logic [1:0]  e_frt;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t        vecs[$];
    logic [36:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic vec_t v(input logic vld, input logic [4:0] rs, input logic rsu,
                               input logic [4:0] rt, input logic rtu, input logic [4:0] rd,
                               input logic wr, input logic [1:0] lat, input logic fl,
                               input logic mb, input logic es, input logic [1:0] efr,
                               input logic [1:0] eft, input logic [31:0] ec);
        vec_t r;
        r.vld = vld; r.rs = rs; r.rsu = rsu; r.rt = rt; r.rtu = rtu;
        r.rd = rd; r.wr = wr; r.lat = lat; r.fl = fl; r.mb = mb;
        r.e_stall = es; r.e_frs = efr; r.e_frt = eft; r.e_cnt = ec;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        id_valid   = r.vld;
        id_rs      = r.rs;
        id_rs_used = r.rsu;
        id_rt      = r.rt;
        id_rt_used = r.rtu;
        id_rd      = r.rd;
        id_wr      = r.wr;
        id_lat     = r.lat;
        flush      = r.fl;
        mem_busy   = r.mb;
    endtask

    task automatic check_outs(input string tag, input logic es, input logic [1:0] efr,
                              input logic [1:0] eft, input logic [31:0] ec);
        chk({tag, " stall"}, 32'(stall), 32'(es));
        chk({tag, " fwd_rs"}, 32'(fwd_rs), 32'(efr));
        chk({tag, " fwd_rt"}, 32'(fwd_rt), 32'(eft));
        chk({tag, " stall_cnt"}, stall_cnt, ec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [36:0] e;
        vec_t        idle;

        idle = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        drive(idle);

        // Held in reset with random inputs and mem_busy low: outputs stay quiet.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            id_valid   = 1'($urandom_range(0, 1));
            id_rs      = 5'($urandom_range(0, 31));
            id_rt      = 5'($urandom_range(0, 31));
            id_rs_used = 1'($urandom_range(0, 1));
            id_rt_used = 1'($urandom_range(0, 1));
            id_rd      = 5'($urandom_range(0, 31));
            id_wr      = 1'($urandom_range(0, 1));
            id_lat     = 2'($urandom_range(0, 3));
            flush      = 1'($urandom_range(0, 1));
            mem_busy   = 1'b0;
            #2;
            check_outs($sformatf("reset_rand%0d", i), 1'b0, 2'd0, 2'd0, 32'd0);
        end
        @(negedge clk);
        drive(idle);
        reset = 1'b1;

        // vld rs rsu rt rtu rd wr lat fl mb | stall frs frt cnt
        vecs.push_back(v(1, 0, 0, 0, 0, 5, 1, L1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        vecs.push_back(v(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(v(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 8, 1, L2, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1));
        vecs.push_back(v(1, 0, 0, 0, 0, 3, 1, L1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, 0, 0, 0, 0, 3, 1, L1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, L1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, 0, 0, 0, 0, 7, 1, 2'd0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(v(1, 0, 0, 0, 0, 6, 1, 2'd3, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(v(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2));
        vecs.push_back(v(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 3));
        vecs.push_back(v(1, 0, 0, 0, 0, 9, 1, L2, 0, 0, 0, 0, 0, 3));
        vecs.push_back(v(1, 9, 1, 0, 0, 9, 1, L1, 1, 0, 0, 0, 0, 3));
        vecs.push_back(v(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 3));
        vecs.push_back(v(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 3));
        vecs.push_back(v(1, 0, 0, 0, 0, 4, 1, L1, 0, 0, 0, 0, 0, 3));
        vecs.push_back(v(1, 4, 1, 0, 0, 10, 1, L1, 0, 1, 1, 1, 0, 3));
        vecs.push_back(v(1, 4, 1, 0, 0, 10, 1, L1, 0, 1, 1, 1, 0, 4));
        vecs.push_back(v(1, 4, 1, 0, 0, 10, 1, L1, 0, 1, 1, 1, 0, 5));
        vecs.push_back(v(1, 4, 1, 0, 0, 10, 1, L1, 0, 0, 0, 1, 0, 6));
        vecs.push_back(v(1, 10, 1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 2, 6));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 6));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            exp_q.push_back({vecs[i].e_stall, vecs[i].e_frs, vecs[i].e_frt, vecs[i].e_cnt});
            #2;
            e = exp_q.pop_front();
            check_outs($sformatf("vec%0d", i), e[36], e[35:34], e[33:32], e[31:0]);
        end

        // Mid-stream asynchronous reset: rd=10 sits in stage 3, rd=4 has left.
        @(negedge clk);
        drive(v(1, 10, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        check_outs("pre_reset", 1'b0, 2'd3, 2'd0, 32'd6);
        reset = 1'b0;
        #1;
        check_outs("async_reset", 1'b0, 2'd0, 2'd0, 32'd0);
        @(posedge clk);
        #1;
        check_outs("held_reset", 1'b0, 2'd0, 2'd0, 32'd0);

        @(negedge clk);
        reset = 1'b1;
        drive(v(1, 0, 0, 0, 0, 5, 1, L1, 0, 0, 0, 0, 0, 0));
        #2;
        check_outs("resume_issue", 1'b0, 2'd0, 2'd0, 32'd0);
        @(negedge clk);
        drive(v(1, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        check_outs("resume_use", 1'b0, 2'd1, 2'd1, 32'd0);

        @(negedge clk);
        drive(idle);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
